pcq_thold_seq: RTL

Parametrised thold and scan-gate distributor for the pervasive clock-control unit. It generates `NUM_DOM` independent stage-5 sl-thold outputs from the stage-6 inputs. It adds per-domain scan selection and a fast-xstop override. Power-management raise/drop is sequenced domain by domain with programmable spacing and a request/acknowledge handshake, so that held-clock current steps are bounded. It sits between the chip-level stage-6 thold tree and the per-unit stage-5 consumers, and replaces the flat single-step thold staging.

---
 rtl/pcq_thold_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pcq_thold_seq.sv
// Per-domain stage-5 thold / scan-gate distributor with a domain-by-domain PM raise/drop sequencer.
// Latency: thold_5/sg_5 lag their inputs by STAGES edges; the fast-xstop path adds one more edge.
// No backpressure: pm_raise_req is a level request, and pm_ack/pm_busy report the sequencer's progress.
// Optional feature: define PCQ_THOLD_SEQ_SLP_EN to build the slp_thold_5 port and its staging.
module pcq_thold_seq #(
    parameter int NUM_DOM = 4,
    parameter int STAGES  = 1,
    parameter int GAP_W   = 4
) (
    input  logic               nclk,
    input  logic               rst_b,
    input  logic               func_sl_thold_6,
    input  logic               sg_6,
    input  logic               ccenable_dc,
    input  logic               lbist_en_dc,
    input  logic               gsd_test_enable_dc,
    input  logic               rg_ck_fast_xstop,
    input  logic [NUM_DOM-1:0] dom_scan_en,
    input  logic               pm_raise_req,
    input  logic [GAP_W-1:0]   pm_gap,
    output logic               pm_ack,
    output logic               pm_busy,
    output logic [NUM_DOM-1:0] thold_5,
`ifdef PCQ_THOLD_SEQ_SLP_EN
    output logic [NUM_DOM-1:0] slp_thold_5,
`endif
    output logic               sg_5
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DOM - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAISING  = 2'd1,
        HELD     = 2'd2,
        DROPPING = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [GAP_W-1:0]   cnt, cnt_nxt;
    logic [NUM_DOM-1:0] pm_mask, pm_mask_nxt;

    logic               sg_in;
    logic               test_ovr;
    logic               xs_q;
    logic               xs_ovr;
    logic [NUM_DOM-1:0] thold_in;

    logic [NUM_DOM-1:0] thold_q [STAGES];
    logic               sg_q    [STAGES];

    // Scan gate only counts when clock control is enabled; any test mode overrides xstop and PM.
    assign sg_in    = sg_6 & ccenable_dc;
    assign test_ovr = sg_in | lbist_en_dc | gsd_test_enable_dc;
    assign xs_ovr   = xs_q & ~test_ovr;

    assign thold_in = {NUM_DOM{func_sl_thold_6 | xs_ovr}}
                    | ({NUM_DOM{sg_in}} & ~dom_scan_en)
                    | (pm_mask & {NUM_DOM{~test_ovr}});

    // Fast-xstop is registered once before it reaches the thold logic.
    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) xs_q <= 1'b0;
        else        xs_q <= rg_ck_fast_xstop;
    end

    // PM sequencer state register.
    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            pm_mask <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            pm_mask <= pm_mask_nxt;
        end
    end

    // Sequencer next-state: one domain per step, pm_gap idle cycles between steps, frozen in test modes.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        pm_mask_nxt = pm_mask;
        if (!test_ovr) begin
            case (state)
                IDLE: begin
                    if (pm_raise_req) begin
                        pm_mask_nxt[0] = 1'b1;
                        idx_nxt        = '0;
                        cnt_nxt        = pm_gap;
                        state_nxt      = RAISING;
                    end
                end
                RAISING: begin
                    if (!pm_raise_req) begin
                        pm_mask_nxt[idx] = 1'b0;
                        cnt_nxt          = pm_gap;
                        state_nxt        = DROPPING;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (idx != LAST) begin
                        idx_nxt              = idx + 1'b1;
                        pm_mask_nxt[idx_nxt] = 1'b1;
                        cnt_nxt              = pm_gap;
                    end else begin
                        state_nxt = HELD;
                    end
                end
                HELD: begin
                    if (!pm_raise_req) begin
                        pm_mask_nxt[LAST] = 1'b0;
                        idx_nxt           = LAST;
                        cnt_nxt           = pm_gap;
                        state_nxt         = DROPPING;
                    end
                end
                DROPPING: begin
                    if (pm_raise_req) begin
                        pm_mask_nxt[idx] = 1'b1;
                        cnt_nxt          = pm_gap;
                        state_nxt        = RAISING;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (idx != '0) begin
                        idx_nxt              = idx - 1'b1;
                        pm_mask_nxt[idx_nxt] = 1'b0;
                        cnt_nxt              = pm_gap;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign pm_ack  = ((state == HELD) & pm_raise_req) | ((state == IDLE) & ~pm_raise_req);
    assign pm_busy = (state == RAISING) | (state == DROPPING);

    // Output staging: tholds reset to held, scan gate resets inactive.
    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            for (int s = 0; s < STAGES; s++) begin
                thold_q[s] <= '1;
                sg_q[s]    <= 1'b0;
            end
        end else begin
            thold_q[0] <= thold_in;
            sg_q[0]    <= sg_in;
            for (int s = 1; s < STAGES; s++) begin
                thold_q[s] <= thold_q[s-1];
                sg_q[s]    <= sg_q[s-1];
            end
        end
    end

    assign thold_5 = thold_q[STAGES-1];
    assign sg_5    = sg_q[STAGES-1];

`ifdef PCQ_THOLD_SEQ_SLP_EN
    logic [NUM_DOM-1:0] slp_in;
    logic [NUM_DOM-1:0] slp_q [STAGES];

    // Sleep domains see every thold source except the PM mask.
    assign slp_in = {NUM_DOM{func_sl_thold_6 | xs_ovr}} | ({NUM_DOM{sg_in}} & ~dom_scan_en);

    // Sleep thold staging, same depth and reset value as the run tholds.
    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            for (int s = 0; s < STAGES; s++) slp_q[s] <= '1;
        end else begin
            slp_q[0] <= slp_in;
            for (int s = 1; s < STAGES; s++) slp_q[s] <= slp_q[s-1];
        end
    end

    assign slp_thold_5 = slp_q[STAGES-1];
`endif

endmodule
